// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 stream-mode packets into a clamped absolute cursor position.
// Optional: define MOUSE_ERR_COUNT_EN to add the saturating ERR_COUNT discard counter.
module mouse_packet_tracker #(
    parameter int X_WIDTH        = 8,
    parameter int Y_WIDTH        = 7,
    parameter int X_MAX          = 159,
    parameter int Y_MAX          = 119,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         BYTE_READ,
    input  logic [1:0]         BYTE_ERROR_CODE,
    input  logic               BYTE_READY,
    output logic               READ_ENABLE,
    output logic [X_WIDTH-1:0] MOUSE_X,
    output logic [Y_WIDTH-1:0] MOUSE_Y,
    output logic [7:0]         MOUSE_STATUS,
    output logic               PACKET_VALID
`ifdef MOUSE_ERR_COUNT_EN
    ,
    output logic [7:0]         ERR_COUNT
`endif
);

    localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WIDE_W  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    // Position plus a 9-bit delta, with headroom for sign and carry.
    localparam int SUM_W   = (WIDE_W + 3 > 11) ? WIDE_W + 3 : 11;

    localparam logic [CNT_W-1:0]        TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [SUM_W-1:0] X_MAX_S  = SUM_W'(X_MAX);
    localparam logic signed [SUM_W-1:0] Y_MAX_S  = SUM_W'(Y_MAX);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } state_t;

    state_t           state;
    logic [7:0]       status_q;
    logic [7:0]       dx_q;
    logic [7:0]       dy_q;
    logic [CNT_W-1:0] timeout_cnt;

    logic                     byte_good;
    logic                     timed_out;
    logic signed [8:0]        dx_s;
    logic signed [8:0]        dy_s;
    logic signed [SUM_W-1:0]  sum_x;
    logic signed [SUM_W-1:0]  sum_y;
    logic [X_WIDTH-1:0]       new_x;
    logic [Y_WIDTH-1:0]       new_y;

    assign byte_good = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign timed_out = !BYTE_READY && (timeout_cnt == TO_LAST);

    // Overflow bits saturate the delta to the extreme of its sign.
    always_comb begin
        dx_s = {status_q[4], dx_q};
        if (status_q[6])
            dx_s = status_q[4] ? 9'h100 : 9'h0FF;
        dy_s = {status_q[5], dy_q};
        if (status_q[7])
            dy_s = status_q[5] ? 9'h100 : 9'h0FF;
    end

    // Screen Y grows downward while mouse dY is positive upward, hence the subtraction.
    always_comb begin
        sum_x = $signed({{(SUM_W-X_WIDTH){1'b0}}, MOUSE_X}) + $signed({{(SUM_W-9){dx_s[8]}}, dx_s});
        sum_y = $signed({{(SUM_W-Y_WIDTH){1'b0}}, MOUSE_Y}) - $signed({{(SUM_W-9){dy_s[8]}}, dy_s});

        if (sum_x < 0)
            new_x = '0;
        else if (sum_x > X_MAX_S)
            new_x = X_WIDTH'(X_MAX);
        else
            new_x = X_WIDTH'(sum_x);

        if (sum_y < 0)
            new_y = '0;
        else if (sum_y > Y_MAX_S)
            new_y = Y_WIDTH'(Y_MAX);
        else
            new_y = Y_WIDTH'(sum_y);
    end

    // NOTE: all state here is updated with <= so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= WAIT_B0;
            status_q     <= 8'h00;
            dx_q         <= 8'h00;
            dy_q         <= 8'h00;
            timeout_cnt  <= '0;
            READ_ENABLE  <= 1'b0;
            MOUSE_X      <= X_WIDTH'(X_MAX / 2);
            MOUSE_Y      <= Y_WIDTH'(Y_MAX / 2);
            MOUSE_STATUS <= 8'h00;
            PACKET_VALID <= 1'b0;
        end else begin
            READ_ENABLE  <= 1'b1;
            PACKET_VALID <= 1'b0;
            case (state)
                WAIT_B0: begin
                    timeout_cnt <= '0;
                    if (byte_good && BYTE_READ[3]) begin
                        status_q <= BYTE_READ;
                        state    <= WAIT_B1;
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (BYTE_READY) begin
                        timeout_cnt <= '0;
                        if (BYTE_ERROR_CODE != 2'b00) begin
                            state <= WAIT_B0;
                        end else if (state == WAIT_B1) begin
                            dx_q  <= BYTE_READ;
                            state <= WAIT_B2;
                        end else begin
                            dy_q  <= BYTE_READ;
                            state <= UPDATE;
                        end
                    end else if (timed_out) begin
                        timeout_cnt <= '0;
                        state       <= WAIT_B0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    MOUSE_X      <= new_x;
                    MOUSE_Y      <= new_y;
                    MOUSE_STATUS <= status_q;
                    PACKET_VALID <= 1'b1;
                    state        <= WAIT_B0;
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

`ifdef MOUSE_ERR_COUNT_EN
    logic discard_event;

    // Receiver errors count in any collecting state; sync failures only at packet start.
    assign discard_event =
        ((state != UPDATE) && BYTE_READY && (BYTE_ERROR_CODE != 2'b00)) ||
        ((state == WAIT_B0) && byte_good && !BYTE_READ[3]) ||
        (((state == WAIT_B1) || (state == WAIT_B2)) && timed_out);

    always_ff @(posedge CLK) begin
        if (RESET)
            ERR_COUNT <= 8'h00;
        else if (discard_event && (ERR_COUNT != 8'hFF))
            ERR_COUNT <= ERR_COUNT + 8'h01;
    end
`endif

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Directed plus randomized bench for mouse_packet_tracker against a packet-level reference model.
module tb_mouse_packet_tracker;

    localparam int T     = 40;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic       READ_ENABLE;
    logic [7:0] MOUSE_X;
    logic [6:0] MOUSE_Y;
    logic [7:0] MOUSE_STATUS;
    logic       PACKET_VALID;
`ifdef MOUSE_ERR_COUNT_EN
    logic [7:0] ERR_COUNT;
`endif

    mouse_packet_tracker #(
        .X_WIDTH(8), .Y_WIDTH(7), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BYTE_READ(BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY),
        .READ_ENABLE(READ_ENABLE),
        .MOUSE_X(MOUSE_X),
        .MOUSE_Y(MOUSE_Y),
        .MOUSE_STATUS(MOUSE_STATUS),
        .PACKET_VALID(PACKET_VALID)
`ifdef MOUSE_ERR_COUNT_EN
        ,
        .ERR_COUNT(ERR_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: packet-level view of the byte stream.
    int         m_x, m_y, m_err, coll, idle;
    logic [7:0] m_status;
    logic [7:0] pk [3];
    bit         m_pv, m_re, busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(input logic sgn, input logic ovf, input logic [7:0] mag);
        if (ovf) return sgn ? -256 : 255;
        return sgn ? int'(mag) - 256 : int'(mag);
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_edge(input bit rst, input bit rdy, input logic [7:0] b, input logic [1:0] e);
        if (rst) begin
            m_x = X_MAX / 2; m_y = Y_MAX / 2; m_status = 8'h00;
            m_pv = 0; m_re = 0; coll = 0; busy = 0; idle = 0; m_err = 0;
        end else begin
            m_re = 1;
            m_pv = 0;
            if (busy) begin
                m_x = clamp(m_x + delta(pk[0][4], pk[0][6], pk[1]), X_MAX);
                m_y = clamp(m_y - delta(pk[0][5], pk[0][7], pk[2]), Y_MAX);
                m_status = pk[0];
                m_pv = 1;
                busy = 0;
            end else if (rdy) begin
                idle = 0;
                if (e != 2'b00) begin
                    bump_err();
                    coll = 0;
                end else if (coll == 0) begin
                    if (b[3]) begin pk[0] = b; coll = 1; end
                    else bump_err();
                end else begin
                    pk[coll] = b;
                    coll++;
                    if (coll == 3) begin busy = 1; coll = 0; end
                end
            end else if (coll > 0) begin
                idle++;
                if (idle == T) begin coll = 0; idle = 0; bump_err(); end
            end
        end
    endtask

    // Drive at the falling edge, let the DUT sample, compare at the next falling edge.
    task automatic step(input bit rst, input bit rdy, input logic [7:0] b, input logic [1:0] e);
        RESET = rst; BYTE_READY = rdy; BYTE_READ = b; BYTE_ERROR_CODE = e;
        @(posedge CLK);
        model_edge(rst, rdy, b, e);
        @(negedge CLK);
        check("read_enable", 32'(READ_ENABLE), 32'(m_re));
        check("packet_valid", 32'(PACKET_VALID), 32'(m_pv));
        check("mouse_x", 32'(MOUSE_X), 32'(m_x));
        check("mouse_y", 32'(MOUSE_Y), 32'(m_y));
        check("mouse_status", 32'(MOUSE_STATUS), 32'(m_status));
`ifdef MOUSE_ERR_COUNT_EN
        check("err_count", 32'(ERR_COUNT), 32'(m_err));
`endif
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom, 2'b00);
    endtask

    task automatic byte_in(input logic [7:0] b, input logic [1:0] e);
        step(0, 1, b, e);
    endtask

    task automatic packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        byte_in(b0, 2'b00); byte_in(b1, 2'b00); byte_in(b2, 2'b00);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 2'b00);
        step(1, 1, 8'h09, 2'b00);
    endtask

    initial begin
        RESET = 1; BYTE_READY = 0; BYTE_READ = 0; BYTE_ERROR_CODE = 0;

        // Reset and idle
        do_reset();
        check("rst_re_low", 32'(READ_ENABLE), 32'd0);
        idle_n(1);
        check("rst_re_first", 32'(READ_ENABLE), 32'd1);
        check("rst_x", 32'(MOUSE_X), 32'd79);
        check("rst_y", 32'(MOUSE_Y), 32'd59);
        check("rst_status", 32'(MOUSE_STATUS), 32'h00);
        idle_n(2);

        // Basic packet, latency N+2, one-cycle strobe
        packet(8'h09, 8'h05, 8'h03);
        check("basic_pv_early", 32'(PACKET_VALID), 32'd0);
        idle_n(1);
        check("basic_pv", 32'(PACKET_VALID), 32'd1);
        check("basic_x", 32'(MOUSE_X), 32'd84);
        check("basic_y", 32'(MOUSE_Y), 32'd56);
        check("basic_status", 32'(MOUSE_STATUS), 32'h09);
        idle_n(1);
        check("basic_pv_drop", 32'(PACKET_VALID), 32'd0);

        // Clamping at left and bottom edges
        do_reset();
        packet(8'h18, 8'hB0, 8'h00); idle_n(2);
        check("clamp_x0", 32'(MOUSE_X), 32'd0);
        packet(8'h28, 8'h00, 8'h80); idle_n(2);
        check("clamp_ymax", 32'(MOUSE_Y), 32'd119);

        // X overflow forces +255
        do_reset();
        packet(8'h48, 8'h00, 8'h00); idle_n(2);
        check("ovf_x", 32'(MOUSE_X), 32'd159);
        check("ovf_y", 32'(MOUSE_Y), 32'd59);

        // Resync on bit3=0, then timeout mid-packet
        do_reset();
        byte_in(8'h05, 2'b00);
        packet(8'h08, 8'h01, 8'h00); idle_n(2);
        check("resync_x", 32'(MOUSE_X), 32'd80);
        byte_in(8'h08, 2'b00); byte_in(8'h01, 2'b00);
        idle_n(T + 5);
        packet(8'h08, 8'h02, 8'h00); idle_n(2);
        check("timeout_x", 32'(MOUSE_X), 32'd82);

        // Receiver error drops the partial packet
        do_reset();
        byte_in(8'h08, 2'b00); byte_in(8'h10, 2'b01); idle_n(3);
        check("err_x", 32'(MOUSE_X), 32'd79);
`ifdef MOUSE_ERR_COUNT_EN
        check("err_count_one", 32'(ERR_COUNT), 32'd1);
`endif
        packet(8'h08, 8'h03, 8'h00); idle_n(2);
        check("err_recover_x", 32'(MOUSE_X), 32'd82);

        // Reset in the middle of a packet
        byte_in(8'h08, 2'b00); byte_in(8'h05, 2'b00);
        step(1, 1, 8'h00, 2'b00);
        byte_in(8'h00, 2'b00); idle_n(3);
        check("midrst_x", 32'(MOUSE_X), 32'd79);

`ifdef MOUSE_ERR_COUNT_EN
        // Saturation of the discard counter
        for (int i = 0; i < 300; i++) byte_in(8'h00, 2'b00);
        check("err_sat", 32'(ERR_COUNT), 32'd255);
        do_reset();
`endif

        // Randomized traffic
        for (int p = 0; p < 1500; p++) begin
            int kind = $urandom_range(0, 99);
            if (kind < 5) begin
                byte_in(8'($urandom) & 8'hF7, 2'b00);
            end else if (kind < 8) begin
                byte_in({4'($urandom), 1'b1, 3'($urandom)}, 2'b00);
                idle_n(T + $urandom_range(1, 4));
            end else if (kind < 9) begin
                step(1, 0, 8'h00, 2'b00);
            end else begin
                for (int k = 0; k < 3; k++) begin
                    logic [7:0] b = 8'($urandom);
                    logic [1:0] e = ($urandom_range(0, 99) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
                    if (k == 0) b[3] = 1'b1;
                    byte_in(b, e);
                    idle_n($urandom_range(0, 3));
                end
            end
        end
        idle_n(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mouse_packet_tracker.md
Name: mouse_packet_tracker

Overview:
Sits directly downstream of the PS/2 mouse byte receiver. Consumes its BYTE_READY/BYTE_READ/BYTE_ERROR_CODE stream and assembles 3-byte stream-mode packets (status, dX, dY). Maintains an absolute cursor position clamped to screen limits in screen coordinates (origin top-left, Y grows downward). Publishes the button/status byte and a one-cycle packet strobe to the display and register logic.

Parameters:
X_WIDTH, 8, width of MOUSE_X.
Y_WIDTH, 7, width of MOUSE_Y.
X_MAX, 159, maximum X coordinate (inclusive).
Y_MAX, 119, maximum Y coordinate (inclusive).
TIMEOUT_CYCLES, 100000, maximum CLK cycles allowed between bytes of one packet.

Ports:
CLK  in  1  system clock.
RESET  in  1  synchronous active-high reset.
BYTE_READ  in  8  byte from receiver; valid when BYTE_READY=1.
BYTE_ERROR_CODE  in  2  receiver error flags; bit0 = parity, bit1 = stop.
BYTE_READY  in  1  one-cycle byte-valid strobe.
READ_ENABLE  out  1  enable to receiver.
MOUSE_X  out  X_WIDTH  cursor X position.
MOUSE_Y  out  Y_WIDTH  cursor Y position.
MOUSE_STATUS  out  8  status byte of the last good packet.
PACKET_VALID  out  1  one-cycle strobe on each position update.

Behaviour:
- Reset is synchronous and active-high on RESET; clock is CLK. Reset values:
  - MOUSE_X = X_MAX/2 (79); MOUSE_Y = Y_MAX/2 (59).
  - MOUSE_STATUS = 0x00; PACKET_VALID = 0; READ_ENABLE = 0.
  - State = WAIT_B0; timeout counter = 0.
- READ_ENABLE is registered. It goes to 1 on the first cycle after RESET deasserts and stays 1.
- A byte is accepted only in a cycle with BYTE_READY=1.
- WAIT_B0:
  - Accepted byte with error code 00 and bit3=1 is latched as status → WAIT_B1.
  - bit3=0 or error≠00: byte is discarded (resync); stay in WAIT_B0.
- WAIT_B1: good byte is latched as dX → WAIT_B2.
- WAIT_B2: good byte is latched as dY → UPDATE.
- Errors and timeout in WAIT_B1/WAIT_B2:
  - Error code ≠00 on an accepted byte → WAIT_B0; partial packet discarded; outputs unchanged.
  - Timeout counter clears on every accepted byte and increments every cycle otherwise.
  - Reaching TIMEOUT_CYCLES-1 → WAIT_B0 with the packet discarded.
  - If timeout and BYTE_READY occur in the same cycle, the byte wins.
- UPDATE lasts exactly one cycle, then returns to WAIT_B0. BYTE_READY during UPDATE is ignored.
- Arithmetic:
  - dx is 9-bit two's complement {status[4], dX}; dy is {status[5], dY}.
  - X overflow (status[6]) forces dx = sign ? −256 : +255. Y overflow (status[7]) does the same for dy.
  - newX = MOUSE_X + dx, computed at ≥11 bits signed and clamped to [0, X_MAX].
  - newY = MOUSE_Y − dy, clamped to [0, Y_MAX].
- Latency: if byte 2 is accepted in cycle N, then in cycle N+2 MOUSE_X, MOUSE_Y and MOUSE_STATUS hold the new values and PACKET_VALID=1 for that cycle only.
- RESET mid-packet drops the packet and restores all reset values.

Optional Feature:
- Macro MOUSE_ERR_COUNT_EN.
- When defined, adds output port ERR_COUNT (8 bits), a saturating counter (stops at 255) cleared by RESET.
- It increments by 1 for each discarded packet or discarded byte, caused by: receiver error, bit3=0 sync failure in WAIT_B0, or inter-byte timeout.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then idle → MOUSE_X=79, MOUSE_Y=59, MOUSE_STATUS=0x00, PACKET_VALID=0; READ_ENABLE=1 from the first cycle after RESET deasserts.
2. Bytes 0x09, 0x05, 0x03 with error 00 → two cycles after the third BYTE_READY: MOUSE_X=84, MOUSE_Y=56, MOUSE_STATUS=0x09, PACKET_VALID high for exactly 1 cycle.
3. Clamping: 0x18, 0xB0, 0x00 → MOUSE_X=0. Then 0x28, 0x00, 0x80 → MOUSE_Y=119.
4. Overflow: 0x48, 0x00, 0x00 from reset → MOUSE_X=159 (dx forced to +255); MOUSE_Y unchanged at 59.
5. Resync and timeout:
   - Lone 0x05 (bit3=0) is discarded; the following 0x08, 0x01, 0x00 gives MOUSE_X=80.
   - 0x08, 0x01, then a gap of TIMEOUT_CYCLES with no byte → no PACKET_VALID; the next three bytes form a fresh packet.
6. Error: 0x08, then 0x10 with BYTE_ERROR_CODE=01 → no PACKET_VALID, position unchanged, ERR_COUNT=1 when MOUSE_ERR_COUNT_EN is defined; next good packet accepted normally.
